fnd_scan_rx: RTL and testbench
==============================

// Module: fnd_scan_rx
// PURPOSE
//   Receive end of the multiplexed 7-segment scan bus (o_seg/o_seg_dp/o_seg_enb
//   driven by the display driver). Samples the bus on clk and recovers six
//   digits as BCD plus DP bits. Reports a complete frame, and converts the two
//   low digits back to a 0..59 value. Serves as a loopback checker and as the
//   front end for reading an external scanned display.
// PARAMETERS
//   SETTLE_CYC   16        consecutive identical samples needed before a digit is accepted
//   TIMEOUT_CYC  1000000   cycles with no enable change before o_stall asserts (20 ms @ 50 MHz)
// PORTS
//   clk            in   1   system clock, 50 MHz
//   rst_n          in   1   asynchronous, active-low reset
//   i_seg          in   7   segment pattern {a,b,c,d,e,f,g}, 1 = lit
//   i_seg_dp       in   1   decimal point of the selected digit
//   i_seg_enb      in   6   digit enables, active-low one-hot; bit k = digit k
//   o_digits       out  24  {d5,...,d0}, 4 bits each: 0-9, 4'hF = blank, 4'hE = invalid pattern
//   o_dp           out  6   DP per digit, captured with the frame
//   o_blank        out  6   digit k pattern was 7'b0000000
//   o_err_seg      out  6   digit k pattern was neither blank nor in the 0-9 table
//   o_value        out  6   d1*10+d0 if d1 and d0 are both 0-9 and the result is <=59, else 6'd63
//   o_frame_valid  out  1   1-cycle pulse when the frame outputs update
//   o_err_enb      out  1   1-cycle pulse when a settled sample has more than one enable low
//   o_stall        out  1   scan stopped (timeout); level
// BEHAVIOUR
//   - All inputs are registered once (r_*). Every decision uses the registered copy.
//   - Reset: all outputs are 0. Internal state is also 0: shadow digits, collect mask,
//     settle counter, timeout counter, and the arm flag (arm resets to 1).
//   - Settle counter:
//     - Cleared when {r_enb, r_seg, r_dp} differs from the previous sample.
//     - Otherwise increments, saturating at SETTLE_CYC.
//   - Enable change: any change of r_enb sets arm=1 and clears the timeout counter.
//   - Capture condition: settle counter reaches SETTLE_CYC-1 while arm=1.
//     - r_enb one-hot-low (bit k):
//       - Decode r_seg into shadow slot k and store r_dp.
//       - Set collect[k] and clear arm. There is at most one capture per enable dwell.
//     - r_enb all ones: no capture and no error; clear arm.
//     - More than one bit low: pulse o_err_enb, no capture, clear arm.
//   - Decode table (1 = lit):
//     - 0:1111110  1:0110000  2:1101101  3:1111001  4:0110011
//     - 5:1011011  6:1011111  7:1110000  8:1111111  9:1110011
//     - blank 0000000 -> 4'hF
//     - any other pattern -> 4'hE with err bit set
//   - Recapturing slot k before the frame completes overwrites slot k. The collect
//     bit stays set.
//   - Frame completion: the cycle after collect becomes 6'b111111:
//     - copy shadow to o_digits, o_dp, o_blank, o_err_seg, o_value;
//     - pulse o_frame_valid and clear collect.
//     - If a capture occurs in that same cycle, it lands in the new collect
//       (the clear takes priority on the old bits only).
//   - Outputs hold between frames. Latency from the settle point of the last
//     digit to o_frame_valid is 2 cycles.
//   - o_value: computed from shadow d1/d0 with 6-bit arithmetic. Any non-numeric
//     digit, or a result >59, gives 63.
//   - Timeout counter: increments each cycle, saturating at TIMEOUT_CYC.
//     - On reaching TIMEOUT_CYC: set o_stall=1, clear collect, discard partial frame.
//     - Any enable change clears o_stall the next cycle.
//     - Frame outputs are not altered by a stall.
//   - Reset mid-frame: all state is cleared immediately (async). The first frame
//     after reset needs all six digits captured afresh.
// TESTING (bench uses SETTLE_CYC=16, TIMEOUT_CYC=1000, dwell=100 cycles/digit)
//   - Reset, then scan: d5..d2 blank, d1=4 (0110011), d0=7 (1110000), dp=0
//     -> o_frame_valid pulse; o_digits=24'hFFFF47; o_blank=6'b111100; o_value=47.
//   - Inject a 5-cycle random i_seg glitch at the start of every dwell, then scan "59"
//     -> glitch ignored; o_value=59; exactly one frame pulse per 6 dwells.
//   - d0 pattern 1010101, d1=3
//     -> o_digits[3:0]=4'hE; o_err_seg=6'b000001; o_value=63.
//   - i_seg_enb=6'b111100 held 100 cycles in place of slot 0
//     -> single o_err_enb pulse; no o_frame_valid until a valid slot-0 dwell follows.
//   - Freeze the scan for 1000 cycles mid-frame -> o_stall=1; frame outputs unchanged;
//     resume -> o_stall=0; next frame is complete only after all 6 slots are recaptured.
//   - Assert rst_n low while 3 slots are collected -> all outputs 0. After release,
//     the first o_frame_valid needs 6 new dwells.

Source files
------------

// File: rtl/fnd_scan_rx.sv
// Receive side of a multiplexed 7-segment scan bus: settles each digit dwell,
// decodes it back to BCD and publishes complete six-digit frames plus a 0..59 value.
module fnd_scan_rx #(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   input  logic [5:0]  i_seg_enb,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_blank,
   output logic [5:0]  o_err_seg,
   output logic [5:0]  o_value,
   output logic        o_frame_valid,
   output logic        o_err_enb,
   output logic        o_stall
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYC - 1);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
   localparam logic [TW-1:0] TMO_HIT    = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1111110: seg_decode = 4'd0;
         7'b0110000: seg_decode = 4'd1;
         7'b1101101: seg_decode = 4'd2;
         7'b1111001: seg_decode = 4'd3;
         7'b0110011: seg_decode = 4'd4;
         7'b1011011: seg_decode = 4'd5;
         7'b1011111: seg_decode = 4'd6;
         7'b1110000: seg_decode = 4'd7;
         7'b1111111: seg_decode = 4'd8;
         7'b1110011: seg_decode = 4'd9;
         7'b0000000: seg_decode = 4'hF;
         default:    seg_decode = 4'hE;
      endcase
   endfunction

   logic [6:0]       r_seg, p_seg;
   logic             r_dp, p_dp;
   logic [5:0]       r_enb, p_enb;
   logic [SW-1:0]    settle_cnt;
   logic [TW-1:0]    tmo_cnt;
   logic             arm;
   logic [5:0]       collect, collect_nxt;
   logic [5:0][3:0]  sh_dig;
   logic [5:0]       sh_dp;

   logic             same, enb_change, settle_hit, capture, multi_low;
   logic             frame_done, timeout_hit;
   logic [5:0]       enb_low, sh_blank, sh_err;
   logic [3:0]       cap_dig;
   logic [5:0]       val_calc;

   // Inputs are registered once, then delayed once more so a sample can be compared
   // with its predecessor for settling and enable-change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= '0;
         r_dp  <= 1'b0;
         r_enb <= '0;
         p_seg <= '0;
         p_dp  <= 1'b0;
         p_enb <= '0;
      end else begin
         r_seg <= i_seg;
         r_dp  <= i_seg_dp;
         r_enb <= i_seg_enb;
         p_seg <= r_seg;
         p_dp  <= r_dp;
         p_enb <= r_enb;
      end
   end

   always_comb begin
      same        = ({r_enb, r_seg, r_dp} == {p_enb, p_seg, p_dp});
      enb_change  = (r_enb != p_enb);
      enb_low     = ~r_enb;
      settle_hit  = same && arm && (settle_cnt == SETTLE_HIT);
      capture     = settle_hit && $onehot(enb_low);
      multi_low   = settle_hit && (enb_low != 6'b0) && !$onehot(enb_low);
      cap_dig     = seg_decode(r_seg);
      frame_done  = (collect == 6'b111111);
      timeout_hit = !enb_change && (tmo_cnt == TMO_HIT);
      // Clearing the completed or stalled frame only drops old bits; a capture in the
      // same cycle still lands in the fresh mask.
      collect_nxt = collect;
      if (frame_done || timeout_hit) collect_nxt = 6'b0;
      if (capture) collect_nxt = collect_nxt | enb_low;
   end

   always_comb begin
      sh_blank = '0;
      sh_err   = '0;
      for (int k = 0; k < 6; k++) begin
         sh_blank[k] = (sh_dig[k] == 4'hF);
         sh_err[k]   = (sh_dig[k] == 4'hE);
      end
      val_calc = 6'd63;
      if (sh_dig[1] <= 4'd5 && sh_dig[0] <= 4'd9)
         val_calc = {2'b00, sh_dig[1]} * 6'd10 + {2'b00, sh_dig[0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         tmo_cnt    <= '0;
         arm        <= 1'b1;
         collect    <= '0;
         sh_dig     <= '0;
         sh_dp      <= '0;
      end else begin
         if (!same) settle_cnt <= '0;
         else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;

         if (enb_change) tmo_cnt <= '0;
         else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;

         if (enb_change) arm <= 1'b1;
         else if (settle_hit) arm <= 1'b0;

         collect <= collect_nxt;
         for (int k = 0; k < 6; k++) begin
            if (capture && enb_low[k]) begin
               sh_dig[k] <= cap_dig;
               sh_dp[k]  <= r_dp;
            end
         end
      end
   end

   // Frame outputs hold between completions; a stall never touches them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_digits      <= '0;
         o_dp          <= '0;
         o_blank       <= '0;
         o_err_seg     <= '0;
         o_value       <= '0;
         o_frame_valid <= 1'b0;
         o_err_enb     <= 1'b0;
         o_stall       <= 1'b0;
      end else begin
         o_frame_valid <= frame_done;
         o_err_enb     <= multi_low;
         if (frame_done) begin
            o_digits  <= sh_dig;
            o_dp      <= sh_dp;
            o_blank   <= sh_blank;
            o_err_seg <= sh_err;
            o_value   <= val_calc;
         end
         if (enb_change) o_stall <= 1'b0;
         else if (timeout_hit) o_stall <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fnd_scan_rx.sv
// Directed bench for fnd_scan_rx: scans hand-built frames over the segment bus
// and compares the recovered frame outputs against hand-computed values.
module tb_fnd_scan_rx;
   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
   localparam logic [6:0] S7 = 7'b1110000, S8 = 7'b1111111, S9 = 7'b1110011;
   localparam logic [6:0] S6 = 7'b1011111, BL = 7'b0000000;
   localparam int DWELL = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  i_seg = '0;
   logic        i_seg_dp = 1'b0;
   logic [5:0]  i_seg_enb = 6'b111111;
   logic [23:0] o_digits;
   logic [5:0]  o_dp, o_blank, o_err_seg, o_value;
   logic        o_frame_valid, o_err_enb, o_stall;

   int checks = 0;
   int errors = 0;
   int fv_count = 0;
   int err_count = 0;

   fnd_scan_rx #(.SETTLE_CYC(16), .TIMEOUT_CYC(1000)) dut (
      .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
      .o_digits(o_digits), .o_dp(o_dp), .o_blank(o_blank), .o_err_seg(o_err_seg),
      .o_value(o_value), .o_frame_valid(o_frame_valid), .o_err_enb(o_err_enb), .o_stall(o_stall)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && o_frame_valid) fv_count++;
      if (rst_n && o_err_enb) err_count++;
   end

   // One enable dwell; optionally a 5-cycle random segment glitch at its start.
   task automatic applyStimulus(input logic [5:0] enb, input logic [6:0] seg, input logic dp,
                                input int cycles, input bit glitch);
      i_seg_enb = enb;
      i_seg_dp  = dp;
      for (int c = 0; c < cycles; c++) begin
         if (glitch && c < 5) i_seg = 7'($urandom);
         else i_seg = seg;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scan_slots(input logic [5:0][6:0] pats, input logic [5:0] dps,
                             input int first, input int last, input bit glitch);
      for (int k = first; k <= last; k++)
         applyStimulus(~(6'b000001 << k), pats[k], dps[k], DWELL, glitch);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (o_digits !== 24'h0) begin errors++; $display("[TB] FAIL reset_digits got %h want 000000", o_digits); end
      checks++; if (o_dp !== 6'b0) begin errors++; $display("[TB] FAIL reset_dp got %b want 000000", o_dp); end
      checks++; if (o_blank !== 6'b0) begin errors++; $display("[TB] FAIL reset_blank got %b want 000000", o_blank); end
      checks++; if (o_err_seg !== 6'b0) begin errors++; $display("[TB] FAIL reset_err_seg got %b want 000000", o_err_seg); end
      checks++; if (o_value !== 6'd0) begin errors++; $display("[TB] FAIL reset_value got %0d want 0", o_value); end
      checks++; if (o_frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv got %b want 0", o_frame_valid); end
      checks++; if (o_err_enb !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_enb got %b want 0", o_err_enb); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", o_stall); end
      rst_n = 1'b1;
      applyStimulus(6'b111111, BL, 1'b0, 30, 1'b0);
   endtask

   task automatic test_basic;
      fv_count = 0; err_count = 0;
      scan_slots({BL, BL, BL, BL, S4, S7}, 6'b0, 0, 5, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL basic_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF47) begin errors++; $display("[TB] FAIL basic_digits got %h want ffff47", o_digits); end
      checks++; if (o_blank !== 6'b111100) begin errors++; $display("[TB] FAIL basic_blank got %b want 111100", o_blank); end
      checks++; if (o_err_seg !== 6'b0) begin errors++; $display("[TB] FAIL basic_err_seg got %b want 000000", o_err_seg); end
      checks++; if (o_value !== 6'd47) begin errors++; $display("[TB] FAIL basic_value got %0d want 47", o_value); end
      checks++; if (o_dp !== 6'b0) begin errors++; $display("[TB] FAIL basic_dp got %b want 000000", o_dp); end
      checks++; if (err_count !== 0) begin errors++; $display("[TB] FAIL basic_err_enb got %0d want 0", err_count); end
   endtask

   task automatic test_glitch;
      fv_count = 0;
      scan_slots({BL, BL, BL, BL, S5, S9}, 6'b001000, 0, 5, 1'b1);
      scan_slots({BL, BL, BL, BL, S5, S9}, 6'b001000, 0, 5, 1'b1);
      checks++; if (fv_count !== 2) begin errors++; $display("[TB] FAIL glitch_frames got %0d want 2", fv_count); end
      checks++; if (o_digits !== 24'hFFFF59) begin errors++; $display("[TB] FAIL glitch_digits got %h want ffff59", o_digits); end
      checks++; if (o_value !== 6'd59) begin errors++; $display("[TB] FAIL glitch_value got %0d want 59", o_value); end
      checks++; if (o_dp !== 6'b001000) begin errors++; $display("[TB] FAIL glitch_dp got %b want 001000", o_dp); end
   endtask

   task automatic test_bad_pattern;
      fv_count = 0;
      scan_slots({BL, BL, BL, BL, S3, 7'b1010101}, 6'b0, 0, 5, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL bad_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF3E) begin errors++; $display("[TB] FAIL bad_digits got %h want ffff3e", o_digits); end
      checks++; if (o_err_seg !== 6'b000001) begin errors++; $display("[TB] FAIL bad_err_seg got %b want 000001", o_err_seg); end
      checks++; if (o_value !== 6'd63) begin errors++; $display("[TB] FAIL bad_value got %0d want 63", o_value); end
   endtask

   task automatic test_value_limit;
      fv_count = 0;
      scan_slots({S8, S2, S1, S6, S6, S0}, 6'b111111, 0, 5, 1'b0);
      checks++; if (o_digits !== 24'h821660) begin errors++; $display("[TB] FAIL limit_digits got %h want 821660", o_digits); end
      checks++; if (o_value !== 6'd63) begin errors++; $display("[TB] FAIL limit_value got %0d want 63", o_value); end
      checks++; if (o_blank !== 6'b0) begin errors++; $display("[TB] FAIL limit_blank got %b want 000000", o_blank); end
      checks++; if (o_dp !== 6'b111111) begin errors++; $display("[TB] FAIL limit_dp got %b want 111111", o_dp); end
   endtask

   task automatic test_recapture;
      fv_count = 0;
      applyStimulus(6'b111110, S1, 1'b0, DWELL, 1'b0);
      applyStimulus(6'b111101, S9, 1'b0, DWELL, 1'b0);
      applyStimulus(6'b111110, S2, 1'b0, DWELL, 1'b0);
      scan_slots({BL, BL, BL, BL, S3, S2}, 6'b0, 1, 5, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL recap_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF32) begin errors++; $display("[TB] FAIL recap_digits got %h want ffff32", o_digits); end
      checks++; if (o_value !== 6'd32) begin errors++; $display("[TB] FAIL recap_value got %0d want 32", o_value); end
   endtask

   task automatic test_err_enb;
      fv_count = 0; err_count = 0;
      scan_slots({BL, BL, BL, BL, S1, S2}, 6'b0, 1, 5, 1'b0);
      applyStimulus(6'b111100, S2, 1'b0, DWELL, 1'b0);
      checks++; if (err_count !== 1) begin errors++; $display("[TB] FAIL enb_err_pulses got %0d want 1", err_count); end
      checks++; if (fv_count !== 0) begin errors++; $display("[TB] FAIL enb_no_frame got %0d want 0", fv_count); end
      applyStimulus(6'b111110, S2, 1'b0, DWELL, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL enb_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF12) begin errors++; $display("[TB] FAIL enb_digits got %h want ffff12", o_digits); end
      checks++; if (o_value !== 6'd12) begin errors++; $display("[TB] FAIL enb_value got %0d want 12", o_value); end
   endtask

   task automatic test_stall;
      fv_count = 0;
      applyStimulus(6'b111101, S8, 1'b0, DWELL, 1'b0);
      applyStimulus(6'b111011, BL, 1'b0, 1100, 1'b0);
      checks++; if (o_stall !== 1'b1) begin errors++; $display("[TB] FAIL stall_set got %b want 1", o_stall); end
      checks++; if (o_digits !== 24'hFFFF12) begin errors++; $display("[TB] FAIL stall_hold_digits got %h want ffff12", o_digits); end
      checks++; if (o_value !== 6'd12) begin errors++; $display("[TB] FAIL stall_hold_value got %0d want 12", o_value); end
      applyStimulus(6'b110111, BL, 1'b0, DWELL, 1'b0);
      checks++; if (o_stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_clear got %b want 0", o_stall); end
      applyStimulus(6'b101111, BL, 1'b0, DWELL, 1'b0);
      applyStimulus(6'b011111, BL, 1'b0, DWELL, 1'b0);
      applyStimulus(6'b111110, S8, 1'b0, DWELL, 1'b0);
      checks++; if (fv_count !== 0) begin errors++; $display("[TB] FAIL stall_partial got %0d want 0", fv_count); end
      scan_slots({BL, BL, BL, BL, S0, S8}, 6'b0, 1, 2, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL stall_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF08) begin errors++; $display("[TB] FAIL stall_digits got %h want ffff08", o_digits); end
      checks++; if (o_value !== 6'd8) begin errors++; $display("[TB] FAIL stall_value got %0d want 8", o_value); end
   endtask

   task automatic test_reset_mid;
      scan_slots({BL, BL, BL, BL, S4, S7}, 6'b0, 3, 5, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_digits !== 24'h0) begin errors++; $display("[TB] FAIL rmid_digits got %h want 000000", o_digits); end
      checks++; if (o_value !== 6'd0) begin errors++; $display("[TB] FAIL rmid_value got %0d want 0", o_value); end
      checks++; if (o_blank !== 6'b0) begin errors++; $display("[TB] FAIL rmid_blank got %b want 000000", o_blank); end
      rst_n = 1'b1;
      fv_count = 0;
      scan_slots({BL, BL, BL, BL, S4, S7}, 6'b0, 0, 2, 1'b0);
      checks++; if (fv_count !== 0) begin errors++; $display("[TB] FAIL rmid_partial got %0d want 0", fv_count); end
      scan_slots({BL, BL, BL, BL, S4, S7}, 6'b0, 3, 5, 1'b0);
      checks++; if (fv_count !== 1) begin errors++; $display("[TB] FAIL rmid_frames got %0d want 1", fv_count); end
      checks++; if (o_digits !== 24'hFFFF47) begin errors++; $display("[TB] FAIL rmid_frame_digits got %h want ffff47", o_digits); end
      checks++; if (o_value !== 6'd47) begin errors++; $display("[TB] FAIL rmid_frame_value got %0d want 47", o_value); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_bad_pattern;
      test_value_limit;
      test_recapture;
      test_err_enb;
      test_stall;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
